sync_downc: RTL
===============

# sync_downc

Synchronous, programmable down counter (countdown timer) for the counter library. It counts from a loaded value to zero on enabled clock edges and flags the terminal count with a one-cycle pulse. It supports one-shot and auto-reload (periodic) modes. It is the fully synchronous, descending counterpart to the team's ripple up counters, and is meant for event timers and dividers that need a clean terminal-count strobe.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (≥2)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- t  input  1  count enable; qualifies each decrement
- load  input  1  load strobe; captures d into counter and reload register
- d  input  WIDTH  load value
- auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled on every edge
- q  output  WIDTH  current count, registered
- tc  output  1  terminal-count pulse, registered, one cycle wide
- busy  output  1  high while in RUN state
- zero  output  1  combinational (q == 0)

## Operation
- Priority per edge: reset > load > t > hold.
- State machine has two states, IDLE and RUN.
- reset=1: q=0, reload register=0, state=IDLE, tc=0.
- load=1 in any state:
  - q<=d and reload<=d; tc<=0.
  - If d!=0, next state is RUN; if d==0, next state is IDLE and no tc is produced.
- IDLE: t is ignored, q holds, tc=0.
- RUN with t=1:
  - q>1: q<=q-1.
  - q==1: q<=0 and tc<=1. In one-shot mode the next state is IDLE. In auto-reload mode it stays RUN.
  - q==0 (auto-reload only): q<=reload, tc<=0.
- RUN with t=0: q holds, tc<=0.
- tc is never high for two consecutive cycles.
- q never underflows: no decrement from 0, no wrap to all-ones.
- Period in auto-reload mode is reload+1 enabled cycles. Values cycle reload…1,0,reload…
- If auto_reload is cleared while q==0 in RUN, the block goes to IDLE on the next edge and q holds at 0.
- busy = (state==RUN).

## Timing
- Load latency is 1 cycle: q shows d on the edge after load is sampled high.
- Decrement latency is 1 cycle per enabled edge.
- tc rises on the same edge where q becomes 0. It is visible while q==0 and lasts one cycle.
- In one-shot mode, busy falls on that same edge.
- load and t in the same cycle: load wins and that cycle produces no decrement.
- load on the cycle where q==1 and t=1: load wins and tc stays 0.
- reset mid-operation: all outputs reach their reset values on the next edge. No tc is emitted even if q==1 and t=1.
- No combinational path from inputs to q, tc or busy. zero depends only on q.

## Structure
- Shared package counter_pkg holds:
  - state encodings: ST_IDLE=1'b0, ST_RUN=1'b1
  - the default width constant CNT_WIDTH=4
- Single module. No sub-module is warranted: the datapath is one register, one decrementer and one comparator.
- Reload register, state and tc are separate registered processes inside sync_downc.

## Test plan
- Reset and idle: assert reset 2 cycles, then t=1 with no load → q=0, tc=0, busy=0, zero=1 for 5 cycles.
- One-shot: load d=3, auto_reload=0, t=1 continuous → q=3,2,1,0,0…; tc=1 only in the cycle q first reads 0; busy falls on that edge.
- Periodic: load d=2, auto_reload=1, t=1 continuous → q=2,1,0,2,1,0…; tc high every 3rd cycle. WIDTH=4 with d=15 → tc every 16 cycles.
- Enable gating: load d=4, then t=1,0,0,1,1,0,1 → q=4,3,3,3,2,1,1,0; tc only on the final edge.
- Load edge cases:
  - load d=15 at q=5 → q=15 next cycle.
  - load with t=1 in the same cycle → no decrement that cycle.
  - load d=0 → IDLE, tc stays 0.
  - load at q==1 with t=1 → q=d, tc=0.
- Reset mid-run: reset asserted at q=1 with t=1 → q=0, tc=0, busy=0 next edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter library: state encodings and default widths.
package counter_pkg;

    localparam int CNT_WIDTH = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage : counter_pkg

// File: rtl/sync_downc.sv
// Synchronous programmable down counter with one-shot / auto-reload modes and
// a registered one-cycle terminal-count strobe.
module sync_downc
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_r;
    state_e           state_next_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;
    logic [WIDTH-1:0] reload_r;
    logic             tc_r;
    logic             tc_next_s;

    // Next-state, next-count and terminal-count decode; load overrides counting.
    always_comb begin
        state_next_s = state_r;
        q_next_s     = q_r;
        tc_next_s    = 1'b0;
        if (load) begin
            q_next_s     = d;
            state_next_s = (d != ZERO_C) ? ST_RUN : ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_IDLE;
                end
                ST_RUN: begin
                    if (q_r == ZERO_C) begin
                        // Only reachable in periodic mode; leaving it parks the counter at 0.
                        if (!auto_reload) begin
                            state_next_s = ST_IDLE;
                        end else if (t) begin
                            q_next_s = reload_r;
                        end else begin
                            q_next_s = q_r;
                        end
                    end else if (t) begin
                        if (q_r == ONE_C) begin
                            q_next_s     = ZERO_C;
                            tc_next_s    = 1'b1;
                            state_next_s = auto_reload ? ST_RUN : ST_IDLE;
                        end else begin
                            q_next_s = q_r - ONE_C;
                        end
                    end else begin
                        q_next_s = q_r;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= ZERO_C;
        end else begin
            q_r <= q_next_s;
        end
    end

    // Reload register captures every load value.
    always_ff @(posedge clk) begin
        if (reset) begin
            reload_r <= ZERO_C;
        end else if (load) begin
            reload_r <= d;
        end
    end

    // Terminal-count strobe register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tc_r <= 1'b0;
        end else begin
            tc_r <= tc_next_s;
        end
    end

    assign q    = q_r;
    assign tc   = tc_r;
    assign busy = (state_r == ST_RUN);
    assign zero = (q_r == ZERO_C);

endmodule : sync_downc
